uart_tx_arbiter: RTL and testbench

- Shares the single on-chip UART transmitter (FPGA_SERIAL_TX path) between NUM_REQ byte-stream requesters, e.g. the CPU MMIO UART port and a hardware status/CSR reporter.
- Arbitration is round-robin at packet granularity: a requester keeps the grant until it sends a byte flagged last, or until it stalls past a timeout.
- Output is a registered valid/ready byte stream feeding the UART transmitter's data_in/data_in_valid/data_in_ready interface.

---
 rtl/uart_tx_arbiter_if.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester-side byte streams, the UART-side byte stream and
//   the arbiter status outputs of uart_tx_arbiter.
//
//   Requester side (NUM_REQ lanes, lane i at bits [8i+7:8i] of req_data):
//     req_data, req_valid, req_last  -> arbiter
//     req_ready                      <- arbiter
//   UART side:
//     tx_data, tx_valid              <- arbiter
//     tx_ready                       -> arbiter
//   Status:
//     grant_id, busy, abort          <- arbiter
//
//   slave  : view used by the arbiter itself
//   master : view used by whatever drives requesters / sinks the UART stream
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  logic [GW-1:0]        grant_id;
  logic                 busy;
  logic                 abort;

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, busy, abort
  );

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, busy, abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte-stream requesters.
//   Arbitration is round-robin per packet: the winner keeps the grant until
//   it sends a byte flagged last, or until it has stalled long enough that
//   the lock is forcibly released (abort pulse).
//
//   Ports:
//     clk    - system clock
//     rst_n  - asynchronous reset, active low
//     bus    - uart_tx_arbiter_if.slave
//              req_data/req_valid/req_last/req_ready : requester streams
//              tx_data/tx_valid/tx_ready             : registered UART stream
//              grant_id : current / last granted requester
//              busy     : a packet lock is held
//              abort    : one-cycle pulse on a timeout release
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.slave    bus
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Counter only ever needs to reach TIMEOUT_CYCLES-1.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    rr_q,    rr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [7:0]       tx_data_q,  tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             abort_q,    abort_d;

  logic [NUM_REQ-1:0] req_ready;
  logic [GW-1:0]      win;
  logic               win_found;
  logic               out_free;
  logic               accept;
  logic [7:0]         grant_byte;

  // Round-robin winner: first valid requester after the last one served.
  always_comb begin
    win       = rr_q;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && bus.req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win       = GW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  assign grant_byte = bus.req_data[8*int'(grant_q) +: 8];
  // Output register can take a new byte if empty or draining this cycle.
  assign out_free   = !tx_valid_q || bus.tx_ready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    abort_d    = 1'b0;
    req_ready  = '0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win;
          state_d = LOCKED;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        req_ready[grant_q] = out_free;
        accept = bus.req_valid[grant_q] && out_free;
        if (accept) begin
          // An accept always beats the timeout threshold.
          cnt_d = '0;
          if (bus.req_last[grant_q]) begin
            state_d = IDLE;
            rr_d    = grant_q;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            abort_d = 1'b1;
            state_d = IDLE;
            rr_d    = grant_q;
          end else if (!bus.req_valid[grant_q]) begin
            // Back-pressured but valid cycles are not a stall.
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register: load on accept, otherwise drain when taken.
    if (accept) begin
      tx_data_d  = grant_byte;
      tx_valid_d = 1'b1;
    end else if (bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= GW'(NUM_REQ - 1);
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == LOCKED);
  assign bus.abort     = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TMO     = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] l);
    bus.req_valid = v;
    bus.req_data  = {d1, d0};
    bus.req_last  = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    bus.tx_ready = 1'b1;
    #1;
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", bus.tx_valid); end
    total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h exp=00", bus.tx_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.abort !== 1'b0) begin bad++; $display("FAIL rst_abort got=%b exp=0", bus.abort); end
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready got=%b exp=00", bus.req_ready); end
    total++; if (bus.grant_id !== 1'b0) begin bad++; $display("FAIL rst_grant got=%0d exp=0", bus.grant_id); end
    step();
    step();
    #2 rst_n = 1'b1;
  endtask

  // req0 sends 0d 0a 31(last)
  task automatic test_single_packet();
    step(); drive(2'b01, 8'h0d, 8'h00, 2'b00);                     // cycle 0
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sp_busy0 got=%b exp=0", bus.busy); end
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL sp_ready_idle got=%b exp=00", bus.req_ready); end
    step();                                                         // cycle 1
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL sp_busy1 got=%b exp=1", bus.busy); end
    total++; if (bus.grant_id !== 1'b0) begin bad++; $display("FAIL sp_grant got=%0d exp=0", bus.grant_id); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL sp_txv1 got=%b exp=0", bus.tx_valid); end
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL sp_ready1 got=%b exp=01", bus.req_ready); end
    step();                                                         // cycle 2
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h0d}) begin bad++; $display("FAIL sp_b0 got=%b/%h exp=1/0d", bus.tx_valid, bus.tx_data); end
    drive(2'b01, 8'h0a, 8'h00, 2'b00);
    step();                                                         // cycle 3
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h0a}) begin bad++; $display("FAIL sp_b1 got=%b/%h exp=1/0a", bus.tx_valid, bus.tx_data); end
    drive(2'b01, 8'h31, 8'h00, 2'b01);
    step();                                                         // cycle 4
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h31}) begin bad++; $display("FAIL sp_b2 got=%b/%h exp=1/31", bus.tx_valid, bus.tx_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sp_busy_end got=%b exp=0", bus.busy); end
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    step();                                                         // cycle 5
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL sp_drain got=%b exp=0", bus.tx_valid); end
  endtask

  // req0 78,79 and req1 41,42 both valid from reset; then a tie goes to req0
  task automatic test_contention();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(); drive(2'b11, 8'h78, 8'h41, 2'b00);                     // cycle 0
    step();                                                         // cycle 1
    total++; if (bus.grant_id !== 1'b0) begin bad++; $display("FAIL ct_grant0 got=%0d exp=0", bus.grant_id); end
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL ct_ready0 got=%b exp=01", bus.req_ready); end
    step();                                                         // cycle 2
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h78}) begin bad++; $display("FAIL ct_b0 got=%b/%h exp=1/78", bus.tx_valid, bus.tx_data); end
    drive(2'b11, 8'h79, 8'h41, 2'b01);
    step();                                                         // cycle 3
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h79}) begin bad++; $display("FAIL ct_b1 got=%b/%h exp=1/79", bus.tx_valid, bus.tx_data); end
    drive(2'b10, 8'h00, 8'h41, 2'b00);
    step();                                                         // cycle 4
    total++; if (bus.grant_id !== 1'b1) begin bad++; $display("FAIL ct_grant1 got=%0d exp=1", bus.grant_id); end
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL ct_ready1 got=%b exp=10", bus.req_ready); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL ct_gap got=%b exp=0", bus.tx_valid); end
    step();                                                         // cycle 5
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h41}) begin bad++; $display("FAIL ct_b2 got=%b/%h exp=1/41", bus.tx_valid, bus.tx_data); end
    drive(2'b10, 8'h00, 8'h42, 2'b10);
    step();                                                         // cycle 6
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h42}) begin bad++; $display("FAIL ct_b3 got=%b/%h exp=1/42", bus.tx_valid, bus.tx_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ct_busy got=%b exp=0", bus.busy); end
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    step(); drive(2'b11, 8'h90, 8'h91, 2'b11);                     // cycle 7: tie
    step();                                                         // cycle 8
    total++; if (bus.grant_id !== 1'b0) begin bad++; $display("FAIL ct_tie got=%0d exp=0", bus.grant_id); end
    step(); drive(2'b00, 8'h00, 8'h00, 2'b00);                     // cycle 9: 90 accepted, released
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h90}) begin bad++; $display("FAIL ct_tieb got=%b/%h exp=1/90", bus.tx_valid, bus.tx_data); end
    step();
  endtask

  // tx_ready 1,0,0,1 while req0 streams a0 a1 a2(last)
  task automatic test_back_pressure();
    step(); drive(2'b01, 8'ha0, 8'h00, 2'b00); bus.tx_ready = 1'b1; // cycle 0
    step();                                                           // cycle 1
    step();                                                           // cycle 2
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'ha0}) begin bad++; $display("FAIL bp_b0 got=%b/%h exp=1/a0", bus.tx_valid, bus.tx_data); end
    drive(2'b01, 8'ha1, 8'h00, 2'b00);
    step();                                                           // cycle 3
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'ha1}) begin bad++; $display("FAIL bp_b1 got=%b/%h exp=1/a1", bus.tx_valid, bus.tx_data); end
    drive(2'b01, 8'ha2, 8'h00, 2'b01); bus.tx_ready = 1'b0;
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_ready_stall got=%b exp=00", bus.req_ready); end
    step();                                                           // cycle 4
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'ha1}) begin bad++; $display("FAIL bp_hold got=%b/%h exp=1/a1", bus.tx_valid, bus.tx_data); end
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_ready_stall2 got=%b exp=00", bus.req_ready); end
    step();                                                           // cycle 5
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'ha1}) begin bad++; $display("FAIL bp_hold2 got=%b/%h exp=1/a1", bus.tx_valid, bus.tx_data); end
    bus.tx_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL bp_ready_go got=%b exp=01", bus.req_ready); end
    step();                                                           // cycle 6
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'ha2}) begin bad++; $display("FAIL bp_b2 got=%b/%h exp=1/a2", bus.tx_valid, bus.tx_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_busy got=%b exp=0", bus.busy); end
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    step();                                                           // cycle 7
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", bus.tx_valid); end
  endtask

  // req1 sends 55 then goes quiet while req0 waits
  task automatic test_timeout();
    int aborts;
    aborts = 0;
    step(); drive(2'b11, 8'hc0, 8'h55, 2'b01);                     // cycle 0
    step();                                                         // cycle 1
    total++; if (bus.grant_id !== 1'b1) begin bad++; $display("FAIL to_grant got=%0d exp=1", bus.grant_id); end
    step();                                                         // cycle 2
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h55}) begin bad++; $display("FAIL to_b0 got=%b/%h exp=1/55", bus.tx_valid, bus.tx_data); end
    drive(2'b01, 8'hc0, 8'h00, 2'b01);
    for (int c = 3; c <= 9; c++) begin
      step();
      if (bus.abort === 1'b1) aborts++;
    end
    total++; if (aborts !== 0) begin bad++; $display("FAIL to_early got=%0d pulses exp=0", aborts); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL to_busy9 got=%b exp=1", bus.busy); end
    step();                                                         // cycle 10
    total++; if (bus.abort !== 1'b1) begin bad++; $display("FAIL to_abort got=%b exp=1", bus.abort); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_busy10 got=%b exp=0", bus.busy); end
    step();                                                         // cycle 11
    total++; if (bus.abort !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", bus.abort); end
    total++; if ({bus.busy, bus.grant_id} !== {1'b1, 1'b0}) begin bad++; $display("FAIL to_regrant got=%b/%0d exp=1/0", bus.busy, bus.grant_id); end
    step();                                                         // cycle 12
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hc0}) begin bad++; $display("FAIL to_c0 got=%b/%h exp=1/c0", bus.tx_valid, bus.tx_data); end
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    step();
  endtask

  // req1 returns with a byte exactly when the stall counter sits at 7
  task automatic test_accept_at_threshold();
    step(); drive(2'b10, 8'h00, 8'h66, 2'b00);                     // cycle 0
    step();                                                         // cycle 1
    step(); drive(2'b00, 8'h00, 8'h00, 2'b00);                     // cycle 2
    for (int c = 3; c <= 9; c++) step();                            // cycle 9: counter == 7
    drive(2'b10, 8'h00, 8'h67, 2'b00);
    step();                                                         // cycle 10
    total++; if (bus.abort !== 1'b0) begin bad++; $display("FAIL th_abort got=%b exp=0", bus.abort); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL th_busy got=%b exp=1", bus.busy); end
    total++; if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h67}) begin bad++; $display("FAIL th_b got=%b/%h exp=1/67", bus.tx_valid, bus.tx_data); end
    drive(2'b10, 8'h00, 8'h68, 2'b10);
    step();                                                         // cycle 11
    total++; if ({bus.tx_valid, bus.tx_data, bus.busy} !== {1'b1, 8'h68, 1'b0}) begin bad++; $display("FAIL th_end got=%b/%h/%b exp=1/68/0", bus.tx_valid, bus.tx_data, bus.busy); end
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    step();
  endtask

  // reset while a byte sits in the output register
  task automatic test_reset_mid_packet();
    step(); drive(2'b01, 8'haa, 8'h00, 2'b00);                     // cycle 0 (rr=1 -> req0)
    step();                                                         // cycle 1
    step(); bus.tx_ready = 1'b0;                                    // cycle 2
    total++; if (bus.tx_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b exp=1", bus.tx_valid); end
    drive(2'b11, 8'hbb, 8'hcc, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.tx_valid, bus.tx_data, bus.busy, bus.req_ready} !== 12'h0) begin bad++; $display("FAIL rm_async got=%b/%h/%b/%b exp=0/00/0/00", bus.tx_valid, bus.tx_data, bus.busy, bus.req_ready); end
    bus.tx_ready = 1'b1;
    step();
    #2 rst_n = 1'b1;
    step();
    total++; if ({bus.busy, bus.grant_id} !== {1'b1, 1'b0}) begin bad++; $display("FAIL rm_first got=%b/%0d exp=1/0", bus.busy, bus.grant_id); end
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rm_ready got=%b exp=01", bus.req_ready); end
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_packet();
    test_contention();
    test_back_pressure();
    test_timeout();
    test_accept_at_threshold();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
